// File: rtl/dds_param_scheduler.sv
// DDS parameter scheduler: accepts timed 128-bit commands on an AXI-Stream
// style port and applies each one to the DDS control registers on the first
// clock edge at which the sample timestamp reaches the command's target time.
module dds_param_scheduler #(
    parameter int unsigned TS_STEP = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         late_clear,
    output logic [47:0]  freq,
    output logic [13:0]  amp,
    output logic [13:0]  phase,
    output logic [13:0]  amp_offset,
    output logic [63:0]  timestamp,
    output logic [63:0]  time_offset,
    output logic         late,
    output logic [31:0]  applied_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] CMD_FREQ  = 2'b00;
    localparam logic [1:0] CMD_AMP   = 2'b01;
    localparam logic [1:0] CMD_PHASE = 2'b10;
    localparam logic [1:0] CMD_TOFS  = 2'b11;

    localparam logic [63:0] TS_INC = 64'(TS_STEP);

    state_t        state_r;
    logic [127:0]  cmd_r;        // held command while waiting for its time
    logic          pend_late_r;  // held command was already due at acceptance

    logic [63:0]   next_ts_s;
    logic [63:0]   in_ta_s;
    logic [63:0]   held_ta_s;
    logic          in_late_s;
    logic          due_s;
    logic          late_kept_s;

    // Handshake is a pure decode of the FSM state register.
    assign s_axis_tready = (state_r == S_IDLE);

    // Timestamp the counter will hold after this edge, plus target-time compares.
    always_comb begin
        next_ts_s   = timestamp;
        in_ta_s     = {s_axis_tdata[127:68], 4'b0000};
        held_ta_s   = {cmd_r[127:68], 4'b0000};
        in_late_s   = 1'b0;
        due_s       = 1'b0;
        late_kept_s = late & ~late_clear;
        if (run) begin
            next_ts_s = timestamp + TS_INC;
        end else begin
            next_ts_s = timestamp;
        end
        in_late_s = (in_ta_s < next_ts_s);
        // A command found late at acceptance is forced through on the next
        // edge even if the timestamp wraps below its target in between.
        due_s     = (next_ts_s >= held_ta_s) || pend_late_r;
    end

    // Accept/wait FSM, timestamp counter and registered DDS parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            cmd_r         <= 128'd0;
            pend_late_r   <= 1'b0;
            freq          <= 48'd0;
            amp           <= 14'd0;
            phase         <= 14'd0;
            amp_offset    <= 14'd0;
            timestamp     <= 64'd0;
            time_offset   <= 64'd0;
            late          <= 1'b0;
            applied_count <= 32'd0;
        end else begin
            timestamp <= next_ts_s;
            case (state_r)
                S_IDLE: begin
                    late <= late_kept_s;
                    if (s_axis_tvalid) begin
                        cmd_r       <= s_axis_tdata;
                        pend_late_r <= in_late_s;
                        state_r     <= S_WAIT;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (due_s) begin
                        case (cmd_r[63:62])
                            CMD_FREQ:  freq        <= cmd_r[47:0];
                            CMD_AMP: begin
                                amp        <= cmd_r[13:0];
                                amp_offset <= cmd_r[29:16];
                            end
                            CMD_PHASE: phase       <= cmd_r[13:0];
                            CMD_TOFS:  time_offset <= next_ts_s;
                            default:   freq        <= freq;
                        endcase
                        late          <= pend_late_r | late_kept_s;
                        applied_count <= applied_count + 32'd1;
                        pend_late_r   <= 1'b0;
                        state_r       <= S_IDLE;
                    end else begin
                        late    <= late_kept_s;
                        state_r <= S_WAIT;
                    end
                end
                default: begin
                    late        <= late_kept_s;
                    pend_late_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_param_scheduler.sv
// Directed self-checking bench for dds_param_scheduler (TS_STEP = 16).
module tb_dds_param_scheduler;

    logic         clk;
    logic         reset;
    logic         run;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         late_clear;
    logic [47:0]  freq;
    logic [13:0]  amp;
    logic [13:0]  phase;
    logic [13:0]  amp_offset;
    logic [63:0]  timestamp;
    logic [63:0]  time_offset;
    logic         late;
    logic [31:0]  applied_count;

    int passed_cnt;
    int total_cnt;

    dds_param_scheduler #(.TS_STEP(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .late_clear    (late_clear),
        .freq          (freq),
        .amp           (amp),
        .phase         (phase),
        .amp_offset    (amp_offset),
        .timestamp     (timestamp),
        .time_offset   (time_offset),
        .late          (late),
        .applied_count (applied_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk_cmd(input logic [63:0] t, input logic [1:0] ty,
                                            input logic [47:0] p);
        return {t, ty, 14'd0, p};
    endfunction

    // One clock edge; outputs are sampled and inputs changed 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; s_axis_tvalid = 1'b0; late_clear = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; late_clear = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h0, 2'b00, 48'hFFFF_FFFF_FFFF);
        step(); step(); step();
        total_cnt++; if (timestamp !== 64'd0) $display("FAIL rst_ts: got %h want 0", timestamp); else passed_cnt++;
        total_cnt++; if (s_axis_tready !== 1'b1) $display("FAIL rst_tready: got %b want 1", s_axis_tready); else passed_cnt++;
        total_cnt++; if ({freq, amp, phase, amp_offset} !== 90'd0) $display("FAIL rst_params: got %h want 0", {freq, amp, phase, amp_offset}); else passed_cnt++;
        total_cnt++; if ({time_offset, applied_count, late} !== 97'd0) $display("FAIL rst_misc: got %h want 0", {time_offset, applied_count, late}); else passed_cnt++;
        s_axis_tvalid = 1'b0; late_clear = 1'b0; run = 1'b0;
        reset = 1'b0;
        step();
        total_cnt++; if (s_axis_tready !== 1'b1 || applied_count !== 32'd0) $display("FAIL rst_release: got tready=%b cnt=%0d want 1/0", s_axis_tready, applied_count); else passed_cnt++;
    endtask

    // Type 00, T=0x100 from timestamp 0: freq appears with timestamp 0x100.
    task automatic test_freq();
        run = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h100, 2'b00, 48'h1234_5678_9ABC);
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++; if (s_axis_tready !== 1'b0) $display("FAIL freq_wait_tready: got %b want 0", s_axis_tready); else passed_cnt++;
        repeat (14) step();
        total_cnt++; if (timestamp !== 64'hF0 || freq !== 48'd0) $display("FAIL freq_early: got ts=%h freq=%h want F0/0", timestamp, freq); else passed_cnt++;
        step();
        total_cnt++; if (timestamp !== 64'h100 || freq !== 48'h1234_5678_9ABC) $display("FAIL freq_apply: got ts=%h freq=%h want 100/123456789abc", timestamp, freq); else passed_cnt++;
        total_cnt++; if (applied_count !== 32'd1 || late !== 1'b0 || s_axis_tready !== 1'b1) $display("FAIL freq_status: got cnt=%0d late=%b rdy=%b want 1/0/1", applied_count, late, s_axis_tready); else passed_cnt++;
    endtask

    // Type 10, T=0x40 sent at timestamp 0x200: applied next edge, late sticky.
    task automatic test_late();
        repeat (16) step();
        total_cnt++; if (timestamp !== 64'h200) $display("FAIL late_ts: got %h want 200", timestamp); else passed_cnt++;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h40, 2'b10, 48'h1ABC);
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++; if (phase !== 14'd0) $display("FAIL late_phase_early: got %h want 0", phase); else passed_cnt++;
        step();
        total_cnt++; if (phase !== 14'h1ABC || late !== 1'b1 || applied_count !== 32'd2) $display("FAIL late_apply: got ph=%h late=%b cnt=%0d want 1abc/1/2", phase, late, applied_count); else passed_cnt++;
        repeat (3) step();
        total_cnt++; if (late !== 1'b1) $display("FAIL late_sticky: got %b want 1", late); else passed_cnt++;
        late_clear = 1'b1;
        step();
        late_clear = 1'b0;
        total_cnt++; if (late !== 1'b0) $display("FAIL late_clear: got %b want 0", late); else passed_cnt++;
    endtask

    // Three past-time commands with tvalid held high.
    task automatic test_back_to_back();
        logic exp_rdy;
        do_reset();
        run = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = mk_cmd(64'h0, 2'b01, 48'h0000_0022_0011);
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i % 2 == 0) ? 1'b1 : 1'b0;
            total_cnt++; if (s_axis_tready !== exp_rdy) $display("FAIL b2b_tready[%0d]: got %b want %b", i, s_axis_tready, exp_rdy); else passed_cnt++;
            if (i == 2) s_axis_tdata = mk_cmd(64'h0, 2'b10, 48'h0333);
            if (i == 4) s_axis_tdata = mk_cmd(64'h0, 2'b00, 48'hFEDC_BA98_7654);
            if (i == 5) s_axis_tvalid = 1'b0;
            step();
        end
        total_cnt++; if (applied_count !== 32'd3 || late !== 1'b1) $display("FAIL b2b_count: got cnt=%0d late=%b want 3/1", applied_count, late); else passed_cnt++;
        total_cnt++; if (amp !== 14'h11 || amp_offset !== 14'h22) $display("FAIL b2b_amp: got %h/%h want 11/22", amp, amp_offset); else passed_cnt++;
        total_cnt++; if (phase !== 14'h333 || freq !== 48'hFEDC_BA98_7654) $display("FAIL b2b_ph_freq: got %h/%h want 333/fedcba987654", phase, freq); else passed_cnt++;
    endtask

    // Pending T=0x1000 with run dropped at 0x800 for 20 cycles.
    task automatic test_freeze();
        int n;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h1000, 2'b00, 48'h0000_0000_BEEF);
        step();
        s_axis_tvalid = 1'b0;
        n = 0;
        while (timestamp !== 64'h800 && n < 300) begin step(); n++; end
        total_cnt++; if (timestamp !== 64'h800) $display("FAIL frz_reach800: got %h want 800", timestamp); else passed_cnt++;
        run = 1'b0;
        repeat (20) step();
        total_cnt++; if (timestamp !== 64'h800 || freq !== 48'hFEDC_BA98_7654) $display("FAIL frz_hold: got ts=%h freq=%h want 800/fedcba987654", timestamp, freq); else passed_cnt++;
        total_cnt++; if (s_axis_tready !== 1'b0 || applied_count !== 32'd3) $display("FAIL frz_state: got rdy=%b cnt=%0d want 0/3", s_axis_tready, applied_count); else passed_cnt++;
        run = 1'b1;
        n = 0;
        while (timestamp !== 64'hFF0 && n < 300) begin step(); n++; end
        total_cnt++; if (timestamp !== 64'hFF0 || freq !== 48'hFEDC_BA98_7654) $display("FAIL frz_early: got ts=%h freq=%h want ff0/fedcba987654", timestamp, freq); else passed_cnt++;
        step();
        total_cnt++; if (timestamp !== 64'h1000 || freq !== 48'hBEEF || applied_count !== 32'd4) $display("FAIL frz_apply: got ts=%h freq=%h cnt=%0d want 1000/beef/4", timestamp, freq, applied_count); else passed_cnt++;
    endtask

    // Type 11 latches the new timestamp; reset discards a pending type 01.
    task automatic test_time_offset_and_reset();
        int n;
        do_reset();
        run = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h300, 2'b11, 48'h0);
        step();
        s_axis_tvalid = 1'b0;
        n = 0;
        while (timestamp !== 64'h2F0 && n < 100) begin step(); n++; end
        total_cnt++; if (timestamp !== 64'h2F0 || time_offset !== 64'd0) $display("FAIL tofs_early: got ts=%h tofs=%h want 2f0/0", timestamp, time_offset); else passed_cnt++;
        step();
        total_cnt++; if (timestamp !== 64'h300 || time_offset !== 64'h300) $display("FAIL tofs_apply: got ts=%h tofs=%h want 300/300", timestamp, time_offset); else passed_cnt++;
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h340, 2'b01, 48'h0000_0567_1234);
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++; if (s_axis_tready !== 1'b0) $display("FAIL rstp_pending: got rdy=%b want 0", s_axis_tready); else passed_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++; if (s_axis_tready !== 1'b1 || timestamp !== 64'd0) $display("FAIL rstp_idle: got rdy=%b ts=%h want 1/0", s_axis_tready, timestamp); else passed_cnt++;
        repeat (60) step();
        total_cnt++; if (timestamp !== 64'h3C0) $display("FAIL rstp_ts: got %h want 3c0", timestamp); else passed_cnt++;
        total_cnt++; if (amp !== 14'd0 || amp_offset !== 14'd0 || applied_count !== 32'd0) $display("FAIL rstp_discard: got amp=%h ofs=%h cnt=%0d want 0/0/0", amp, amp_offset, applied_count); else passed_cnt++;
    endtask

    // Target equal to next timestamp at acceptance is on time, not late.
    task automatic test_on_time();
        s_axis_tvalid = 1'b1; s_axis_tdata = mk_cmd(64'h3DF, 2'b10, 48'h0055);
        step();
        s_axis_tvalid = 1'b0;
        total_cnt++; if (phase !== 14'd0 || s_axis_tready !== 1'b0) $display("FAIL ontime_wait: got ph=%h rdy=%b want 0/0", phase, s_axis_tready); else passed_cnt++;
        step();
        total_cnt++; if (phase !== 14'h55 || late !== 1'b0 || timestamp !== 64'h3E0) $display("FAIL ontime_apply: got ph=%h late=%b ts=%h want 55/0/3e0", phase, late, timestamp); else passed_cnt++;
    endtask

    initial begin
        passed_cnt = 0;
        total_cnt = 0;
        reset = 1'b1; run = 1'b0; s_axis_tvalid = 1'b0; late_clear = 1'b0;
        s_axis_tdata = 128'd0;
        test_reset();
        test_freq();
        test_late();
        test_back_to_back();
        test_freeze();
        test_time_offset_and_reset();
        test_on_time();
        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
